// File: rtl/mc_ctrl_if.sv
// Control bundle between the multicycle controller and the datapath.
// master = controller side, slave = datapath side.
interface mc_ctrl_if #(
  parameter int unsigned IR_W   = 16,
  parameter int unsigned REG_AW = 3
) ();

  logic [IR_W-1:0]   ir;
  logic              c_flag;
  logic              z_flag;
  logic              eq;
  logic              mem_ready;

  logic              ir_we;
  logic              pc_we;
  logic [1:0]        pc_sel;
  logic              mem_rd;
  logic              mem_wr;
  logic              addr_inc;
  logic              rf_we;
  logic [REG_AW-1:0] rf_wa;
  logic [1:0]        rf_din_sel;
  logic [1:0]        alu_a_sel;
  logic [1:0]        alu_b_sel;
  logic [1:0]        alu_op;
  logic              cz_we;
  logic              illegal;
  logic [3:0]        state;

  modport master (
    input  ir, c_flag, z_flag, eq, mem_ready,
    output ir_we, pc_we, pc_sel, mem_rd, mem_wr, addr_inc,
           rf_we, rf_wa, rf_din_sel, alu_a_sel, alu_b_sel, alu_op,
           cz_we, illegal, state
  );

  modport slave (
    output ir, c_flag, z_flag, eq, mem_ready,
    input  ir_we, pc_we, pc_sel, mem_rd, mem_wr, addr_inc,
           rf_we, rf_wa, rf_din_sel, alu_a_sel, alu_b_sel, alu_op,
           cz_we, illegal, state
  );

endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multicycle RISC control unit: state register, dispatch and per-state
// control decode, including memory handshake and LM/SM register sequencing.
module mc_ctrl_fsm #(
  parameter int unsigned IR_W   = 16,
  parameter int unsigned NREG   = 8,
  parameter int unsigned REG_AW = 3
) (
  input  logic      clk,
  input  logic      reset,
  mc_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_WB_ALU   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_WB_LHI   = 4'd8,
    S_BR_CMP   = 4'd9,
    S_BR_TAKE  = 4'd10,
    S_JUMP     = 4'd11,
    S_MULTI    = 4'd12
  } state_e;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_ADI  = 4'b0001;
  localparam logic [3:0] OP_NAND = 4'b0010;
  localparam logic [3:0] OP_LHI  = 4'b0011;
  localparam logic [3:0] OP_LW   = 4'b0100;
  localparam logic [3:0] OP_SW   = 4'b0101;
  localparam logic [3:0] OP_LM   = 4'b0110;
  localparam logic [3:0] OP_SM   = 4'b0111;
  localparam logic [3:0] OP_JAL  = 4'b1000;
  localparam logic [3:0] OP_JLR  = 4'b1001;
  localparam logic [3:0] OP_BEQ  = 4'b1100;

  state_e            state_q, state_d;
  logic [REG_AW-1:0] idx_q, idx_d;

  logic [3:0]        opcode;
  logic              mask_bit;
  logic              idx_last;
  logic              multi_step;

  logic              ir_we, pc_we, mem_rd, mem_wr, addr_inc, rf_we, cz_we, illegal;
  logic [1:0]        pc_sel, rf_din_sel, alu_a_sel, alu_b_sel, alu_op;
  logic [REG_AW-1:0] rf_wa;

  assign opcode   = bus.ir[IR_W-1 -: 4];
  assign mask_bit = bus.ir[idx_q];
  assign idx_last = (idx_q == REG_AW'(NREG - 1));

  // State and LM/SM index register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next state and control decode; every strobe is suppressed while reset is high
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    multi_step = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = 2'd0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    addr_inc   = 1'b0;
    rf_we      = 1'b0;
    rf_wa      = '0;
    rf_din_sel = 2'd0;
    alu_a_sel  = 2'd0;
    alu_b_sel  = 2'd0;
    alu_op     = 2'd0;
    cz_we      = 1'b0;
    illegal    = 1'b0;

    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_rd = 1'b1;
          if (bus.mem_ready) begin
            ir_we   = 1'b1;
            pc_we   = 1'b1;
            state_d = S_DECODE;
          end
        end

        S_DECODE: begin
          case (opcode)
            OP_ADD, OP_NAND: begin
              // ADC/ADZ-style variants retire without effect when their flag is clear
              if ((bus.ir[1:0] == 2'b10 && !bus.c_flag) ||
                  (bus.ir[1:0] == 2'b01 && !bus.z_flag))
                state_d = S_FETCH;
              else
                state_d = S_EXEC_R;
            end
            OP_ADI:          state_d = S_EXEC_I;
            OP_LHI:          state_d = S_WB_LHI;
            OP_LW, OP_SW:    state_d = S_MEM_ADDR;
            OP_LM, OP_SM: begin
              state_d = S_MULTI;
              idx_d   = '0;
            end
            OP_BEQ:          state_d = S_BR_CMP;
            OP_JAL, OP_JLR:  state_d = S_JUMP;
            default: begin
              illegal = 1'b1;
              state_d = S_FETCH;
            end
          endcase
        end

        S_EXEC_R: begin
          alu_op  = (opcode == OP_NAND) ? 2'd1 : 2'd0;
          cz_we   = 1'b1;
          state_d = S_WB_ALU;
        end

        S_EXEC_I: begin
          alu_b_sel = 2'd1;
          cz_we     = 1'b1;
          state_d   = S_WB_ALU;
        end

        S_WB_ALU: begin
          rf_we   = 1'b1;
          rf_wa   = (opcode == OP_ADI) ? REG_AW'(bus.ir[8:6]) : REG_AW'(bus.ir[5:3]);
          state_d = S_FETCH;
        end

        S_WB_LHI: begin
          rf_we      = 1'b1;
          rf_din_sel = 2'd2;
          rf_wa      = REG_AW'(bus.ir[11:9]);
          state_d    = S_FETCH;
        end

        S_MEM_ADDR: begin
          alu_b_sel = 2'd1;
          state_d   = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
        end

        S_MEM_RD: begin
          mem_rd = 1'b1;
          if (bus.mem_ready) begin
            rf_we      = 1'b1;
            rf_din_sel = 2'd1;
            rf_wa      = REG_AW'(bus.ir[11:9]);
            cz_we      = 1'b1;
            state_d    = S_FETCH;
          end
        end

        S_MEM_WR: begin
          mem_wr = 1'b1;
          if (bus.mem_ready) state_d = S_FETCH;
        end

        S_BR_CMP: begin
          alu_op  = 2'd2;
          state_d = bus.eq ? S_BR_TAKE : S_FETCH;
        end

        S_BR_TAKE: begin
          pc_we   = 1'b1;
          pc_sel  = 2'd1;
          state_d = S_FETCH;
        end

        // Link register receives the PC already advanced during FETCH
        S_JUMP: begin
          rf_we      = 1'b1;
          rf_din_sel = 2'd3;
          rf_wa      = REG_AW'(bus.ir[11:9]);
          pc_we      = 1'b1;
          pc_sel     = (opcode == OP_JLR) ? 2'd2 : 2'd1;
          state_d    = S_FETCH;
        end

        S_MULTI: begin
          if (mask_bit) begin
            mem_rd = (opcode == OP_LM);
            mem_wr = (opcode != OP_LM);
            if (bus.mem_ready) begin
              addr_inc   = 1'b1;
              multi_step = 1'b1;
              if (opcode == OP_LM) begin
                rf_we      = 1'b1;
                rf_din_sel = 2'd1;
                rf_wa      = idx_q;
              end
            end
          end else begin
            multi_step = 1'b1;
          end
          if (multi_step) begin
            idx_d = idx_last ? '0 : idx_q + REG_AW'(1);
            if (idx_last) state_d = S_FETCH;
          end
        end

        default: state_d = S_FETCH;
      endcase
    end
  end

  assign bus.ir_we      = ir_we;
  assign bus.pc_we      = pc_we;
  assign bus.pc_sel     = pc_sel;
  assign bus.mem_rd     = mem_rd;
  assign bus.mem_wr     = mem_wr;
  assign bus.addr_inc   = addr_inc;
  assign bus.rf_we      = rf_we;
  assign bus.rf_wa      = rf_wa;
  assign bus.rf_din_sel = rf_din_sel;
  assign bus.alu_a_sel  = alu_a_sel;
  assign bus.alu_b_sel  = alu_b_sel;
  assign bus.alu_op     = alu_op;
  assign bus.cz_we      = cz_we;
  assign bus.illegal    = illegal;
  assign bus.state      = reset ? 4'(S_FETCH) : 4'(state_q);

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Parametrised control unit for the multicycle 16-bit RISC core. It combines the state register, next-state logic and per-state control decode in one block. Compared with the earlier controller it adds:
- a memory ready handshake,
- flag-conditional ALU ops,
- BEQ resolution,
- LM/SM multi-register sequencing with an internal index counter.

It sits between the IR/flag registers and the datapath muxes, RF, ALU and memory port.

Parameters:
IR_W, 16, instruction width; opcode is IR[IR_W-1:IR_W-4].
NREG, 8, register count; LM/SM mask is IR[NREG-1:0].
REG_AW, 3, register address width; must equal clog2(NREG).

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high
ir  in  IR_W  current instruction register contents
c_flag  in  1  stored carry flag
z_flag  in  1  stored zero flag
eq  in  1  ALU compare-equal (valid in BR_CMP)
mem_ready  in  1  memory access completes this cycle
ir_we  out  1  load IR from memory data
pc_we  out  1  load PC
pc_sel  out  2  PC source: 0 = PC+1, 1 = PC+imm, 2 = RB
mem_rd  out  1  memory read request
mem_wr  out  1  memory write request
addr_inc  out  1  increment LM/SM address register
rf_we  out  1  register file write enable
rf_wa  out  REG_AW  register write address
rf_din_sel  out  2  RF data source: 0 = ALU, 1 = mem, 2 = LHI imm, 3 = PC
alu_a_sel  out  2  ALU A source: 0 = RA, 1 = PC, 2 = addr register
alu_b_sel  out  2  ALU B source: 0 = RB, 1 = SE6, 2 = SE9, 3 = const 1
alu_op  out  2  ALU operation: 0 = add, 1 = nand, 2 = sub
cz_we  out  1  flag register write enable
illegal  out  1  one-cycle pulse on an undefined opcode
state  out  4  current state, for debug

Behaviour:
- Reset is synchronous. While reset is high, all outputs are 0 except state, which shows FETCH. After reset: state = FETCH, idx = 0.
- Outputs are a Moore decode of state. ir_we, pc_we and rf_we in memory states are additionally qualified by mem_ready.
- States: FETCH, DECODE, EXEC_R, EXEC_I, WB_ALU, MEM_ADDR, MEM_RD, MEM_WR, WB_LHI, BR_CMP, BR_TAKE, JUMP, MULTI.
- FETCH:
  - mem_rd = 1 and held until mem_ready.
  - On mem_ready: ir_we = 1, pc_we = 1 (pc_sel = 0), then go to DECODE.
  - With no mem_ready, stay in FETCH indefinitely with no strobes.
- DECODE dispatch on opcode:
  - 0000 add-class and 0010 nand-class go to EXEC_R. If IR[1:0] = 10 and c_flag = 0, or IR[1:0] = 01 and z_flag = 0, the instruction is skipped and the next state is FETCH.
  - 0001 ADI goes to EXEC_I.
  - 0011 LHI goes to WB_LHI.
  - 0100 LW and 0101 SW go to MEM_ADDR.
  - 0110 LM and 0111 SM go to MULTI with idx = 0.
  - 1100 BEQ goes to BR_CMP.
  - 1000 JAL and 1001 JLR go to JUMP.
  - Any other opcode: illegal = 1, next state FETCH.
- EXEC_R: alu_a_sel = 0, alu_b_sel = 0, alu_op = 0 for add-class or 1 for nand-class, cz_we = 1. Next state WB_ALU.
- EXEC_I: alu_a_sel = 0, alu_b_sel = 1, add, cz_we = 1. Next state WB_ALU.
- WB_ALU: rf_we = 1, rf_din_sel = 0. rf_wa = IR[5:3] for R-type, IR[8:6] for ADI. Next state FETCH.
- WB_LHI: rf_we = 1, rf_din_sel = 2, rf_wa = IR[11:9]. Next state FETCH.
- MEM_ADDR: alu_a_sel = 0, alu_b_sel = 1, add. Next state MEM_RD for LW, MEM_WR for SW.
- MEM_RD: mem_rd = 1. On mem_ready: rf_we = 1, rf_din_sel = 1, rf_wa = IR[11:9], cz_we = 1, then FETCH.
- MEM_WR: mem_wr = 1 until mem_ready, then FETCH.
- BR_CMP: alu_op = 2. If eq, go to BR_TAKE; otherwise go to FETCH.
- BR_TAKE: pc_we = 1, pc_sel = 1. Next state FETCH.
- JUMP:
  - rf_we = 1, rf_din_sel = 3, rf_wa = IR[11:9].
  - pc_we = 1; pc_sel = 1 for JAL, 2 for JLR.
  - Next state FETCH.
  - The RF captures the already-incremented PC.
- MULTI (idx is a REG_AW-bit counter):
  - If IR[idx] = 0: no strobes, idx++ next cycle.
  - If IR[idx] = 1: assert mem_rd (LM) or mem_wr (SM) until mem_ready. On mem_ready, addr_inc = 1 and idx++. For LM, also rf_we = 1, rf_din_sel = 1, rf_wa = idx.
  - The step that completes idx = NREG-1 returns to FETCH and clears idx.
  - An empty mask takes exactly NREG cycles in MULTI.
- Reset asserted mid-MULTI or mid-wait: next state FETCH and idx = 0. No strobe is emitted in the reset cycle.
- mem_rd and mem_wr are never asserted together.

Test Plan:
- ADD R3 = R1 + R2 (ir = 0x0298), mem_ready tied high → FETCH → DECODE → EXEC_R → WB_ALU → FETCH; rf_we = 1 with rf_wa = 3 exactly once; cz_we = 1 in EXEC_R.
- ADC with c_flag = 0 → DECODE → FETCH; no rf_we, no cz_we. Repeat with c_flag = 1 → full writeback path.
- LW with mem_ready delayed 3 cycles in MEM_RD → mem_rd held 4 cycles; rf_we pulses only in the mem_ready cycle; rf_wa = IR[11:9].
- LM with mask 0x85 → exactly 3 rf_we pulses with rf_wa = 0, 2, 7 and 3 addr_inc pulses; 8 cycles in MULTI, then FETCH.
- BEQ with eq = 1 → BR_TAKE asserts pc_we with pc_sel = 1; with eq = 0 → FETCH with no pc_we.
- Reset during LM at idx = 4 → state = FETCH, all outputs 0; next LM restarts from idx = 0. Opcode 1111 → illegal pulses once and state returns to FETCH.
